// File: rtl/mini_calc_arbiter.sv
// mini_calc_arbiter
// Shares a single MiniCalc datapath between two valid/ready requesters.
// Requesters are granted round-robin. The granted instruction and operands
// are registered onto the datapath inputs and held for CALC_LATENCY cycles.
// The datapath results are then captured and returned on the granted
// requester's response channel. Only one operation is in flight at a time.

module mini_calc_arbiter #(
    parameter int                         INPUT_BIT_WIDTH = 8,
    parameter int                         INSTR_BIT_WIDTH = 4,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = 4'b1111,
    parameter int                         CALC_LATENCY    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    // requester 0 command channel
    input  logic                       req0_valid_i,
    output logic                       req0_ready_o,
    input  logic [INSTR_BIT_WIDTH-1:0] req0_instr_i,
    input  logic [INPUT_BIT_WIDTH-1:0] req0_a_i,
    input  logic [INPUT_BIT_WIDTH-1:0] req0_b_i,

    // requester 1 command channel
    input  logic                       req1_valid_i,
    output logic                       req1_ready_o,
    input  logic [INSTR_BIT_WIDTH-1:0] req1_instr_i,
    input  logic [INPUT_BIT_WIDTH-1:0] req1_a_i,
    input  logic [INPUT_BIT_WIDTH-1:0] req1_b_i,

    // requester 0 response channel
    output logic                       rsp0_valid_o,
    input  logic                       rsp0_ready_i,
    output logic [INPUT_BIT_WIDTH-1:0] rsp0_a_o,
    output logic [INPUT_BIT_WIDTH-1:0] rsp0_b_o,

    // requester 1 response channel
    output logic                       rsp1_valid_o,
    input  logic                       rsp1_ready_i,
    output logic [INPUT_BIT_WIDTH-1:0] rsp1_a_o,
    output logic [INPUT_BIT_WIDTH-1:0] rsp1_b_o,

    // MiniCalc datapath connection
    output logic [INSTR_BIT_WIDTH-1:0] calc_instruction_o,
    output logic [INPUT_BIT_WIDTH-1:0] calc_input_a_o,
    output logic [INPUT_BIT_WIDTH-1:0] calc_input_b_o,
    input  logic [INPUT_BIT_WIDTH-1:0] calc_output_a_i,
    input  logic [INPUT_BIT_WIDTH-1:0] calc_output_b_i,

    output logic                       busy_o
);

    // Counter holds CALC_LATENCY-1 down to 0; never narrower than one bit.
    localparam int CNT_W = (CALC_LATENCY < 2) ? 1 : $clog2(CALC_LATENCY + 1);

    localparam logic [CNT_W-1:0]           CNT_LOAD  = CNT_W'(CALC_LATENCY - 1);
    localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]           CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [INPUT_BIT_WIDTH-1:0] DATA_ZERO = {INPUT_BIT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // state and datapath registers
    state_e                     state_q,      state_d;
    logic [CNT_W-1:0]           cnt_q,        cnt_d;
    logic                       owner_q,      owner_d;
    logic                       last_grant_q, last_grant_d;
    logic [INSTR_BIT_WIDTH-1:0] calc_instr_q, calc_instr_d;
    logic [INPUT_BIT_WIDTH-1:0] calc_a_q,     calc_a_d;
    logic [INPUT_BIT_WIDTH-1:0] calc_b_q,     calc_b_d;
    logic                       rsp0_valid_q, rsp0_valid_d;
    logic [INPUT_BIT_WIDTH-1:0] rsp0_a_q,     rsp0_a_d;
    logic [INPUT_BIT_WIDTH-1:0] rsp0_b_q,     rsp0_b_d;
    logic                       rsp1_valid_q, rsp1_valid_d;
    logic [INPUT_BIT_WIDTH-1:0] rsp1_a_q,     rsp1_a_d;
    logic [INPUT_BIT_WIDTH-1:0] rsp1_b_q,     rsp1_b_d;
    logic                       busy_q,       busy_d;

    // combinational arbitration signals
    logic                       idle_s;
    logic                       grant_any_s;
    logic                       grant_sel_s;
    logic                       req0_ready_s;
    logic                       req1_ready_s;
    logic [INSTR_BIT_WIDTH-1:0] sel_instr_s;
    logic [INPUT_BIT_WIDTH-1:0] sel_a_s;
    logic [INPUT_BIT_WIDTH-1:0] sel_b_s;

    assign idle_s      = (state_q == ST_IDLE);
    assign grant_any_s = req0_valid_i | req1_valid_i;

    // Round-robin pick: a lone valid wins, contention goes to the requester not granted last.
    always_comb begin
        grant_sel_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_sel_s = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant_sel_s = 1'b1;
        end else begin
            grant_sel_s = 1'b0;
        end
    end

    // Ready is offered only while idle and only to the requester picked above.
    always_comb begin
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (idle_s && grant_any_s) begin
            if (grant_sel_s) begin
                req1_ready_s = 1'b1;
            end else begin
                req0_ready_s = 1'b1;
            end
        end else begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end
    end

    // Steer the granted requester's instruction and operands toward the datapath registers.
    always_comb begin
        sel_instr_s = req0_instr_i;
        sel_a_s     = req0_a_i;
        sel_b_s     = req0_b_i;
        if (grant_sel_s) begin
            sel_instr_s = req1_instr_i;
            sel_a_s     = req1_a_i;
            sel_b_s     = req1_b_i;
        end else begin
            sel_instr_s = req0_instr_i;
            sel_a_s     = req0_a_i;
            sel_b_s     = req0_b_i;
        end
    end

    // Next-state logic: accept in IDLE, hold inputs in EXEC, hand back the result in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        calc_instr_d = calc_instr_q;
        calc_a_d     = calc_a_q;
        calc_b_d     = calc_b_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp0_a_d     = rsp0_a_q;
        rsp0_b_d     = rsp0_b_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_a_d     = rsp1_a_q;
        rsp1_b_d     = rsp1_b_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    calc_instr_d = sel_instr_s;
                    calc_a_d     = sel_a_s;
                    calc_b_d     = sel_b_s;
                    owner_d      = grant_sel_s;
                    last_grant_d = grant_sel_s;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_EXEC;
                end else begin
                    calc_instr_d = CODE_INSTR_NOP;
                    calc_a_d     = DATA_ZERO;
                    calc_b_d     = DATA_ZERO;
                end
            end

            ST_EXEC: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Datapath inputs have settled; sample results for the owner.
                    if (owner_q) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_a_d     = calc_output_a_i;
                        rsp1_b_d     = calc_output_b_i;
                    end else begin
                        rsp0_valid_d = 1'b1;
                        rsp0_a_d     = calc_output_a_i;
                        rsp0_b_d     = calc_output_b_i;
                    end
                    calc_instr_d = CODE_INSTR_NOP;
                    calc_a_d     = DATA_ZERO;
                    calc_b_d     = DATA_ZERO;
                    state_d      = ST_RESP;
                end
            end

            ST_RESP: begin
                if (owner_q) begin
                    if (rsp1_ready_i) begin
                        rsp1_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        rsp1_valid_d = 1'b1;
                    end
                end else begin
                    if (rsp0_ready_i) begin
                        rsp0_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        rsp0_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                // Unreachable encoding: drop any response and park safely.
                state_d      = ST_IDLE;
                calc_instr_d = CODE_INSTR_NOP;
                calc_a_d     = DATA_ZERO;
                calc_b_d     = DATA_ZERO;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                cnt_d        = CNT_ZERO;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            calc_instr_q <= CODE_INSTR_NOP;
            calc_a_q     <= DATA_ZERO;
            calc_b_q     <= DATA_ZERO;
            rsp0_valid_q <= 1'b0;
            rsp0_a_q     <= DATA_ZERO;
            rsp0_b_q     <= DATA_ZERO;
            rsp1_valid_q <= 1'b0;
            rsp1_a_q     <= DATA_ZERO;
            rsp1_b_q     <= DATA_ZERO;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            calc_instr_q <= calc_instr_d;
            calc_a_q     <= calc_a_d;
            calc_b_q     <= calc_b_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_a_q     <= rsp0_a_d;
            rsp0_b_q     <= rsp0_b_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_a_q     <= rsp1_a_d;
            rsp1_b_q     <= rsp1_b_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready_o       = req0_ready_s;
    assign req1_ready_o       = req1_ready_s;
    assign rsp0_valid_o       = rsp0_valid_q;
    assign rsp0_a_o           = rsp0_a_q;
    assign rsp0_b_o           = rsp0_b_q;
    assign rsp1_valid_o       = rsp1_valid_q;
    assign rsp1_a_o           = rsp1_a_q;
    assign rsp1_b_o           = rsp1_b_q;
    assign calc_instruction_o = calc_instr_q;
    assign calc_input_a_o     = calc_a_q;
    assign calc_input_b_o     = calc_b_q;
    assign busy_o             = busy_q;

endmodule
